// File: rtl/core_mem_pkg.sv
// Shared load/store definitions: funct3 encodings, load FSM states and
// small helpers for access size and word-crossing detection.
package core_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ1 = 2'd1,
      READ2 = 2'd2,
      RESP  = 2'd3
   } ld_state_e;

   // Access size in bytes, taken from the low two funct3 bits.
   function automatic logic [2:0] ld_nbytes(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // True when the access spills into the next 32-bit word.
   function automatic logic ld_split(input logic [1:0] off, input logic [2:0] f3);
      logic [2:0] end_byte;
      end_byte = {1'b0, off} + ld_nbytes(f3);
      return end_byte > 3'd4;
   endfunction

   function automatic logic ld_legal(input logic [2:0] f3);
      case (f3)
         F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
         default:                             return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte selection and sign/zero extension of a load result
// assembled from one or two little-endian bus words.
module load_extract
   import core_mem_pkg::*;
(
   input  logic [31:0] word1_i,
   input  logic [31:0] word2_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;

   // Shift {word2,word1} right by the byte offset, keeping the low word.
   always_comb begin
      case (off_i)
         2'd0:    shifted = word1_i;
         2'd1:    shifted = {word2_i[7:0],  word1_i[31:8]};
         2'd2:    shifted = {word2_i[15:0], word1_i[31:16]};
         default: shifted = {word2_i[23:0], word1_i[31:24]};
      endcase
   end

   // Truncate to the access size and extend according to the load type.
   always_comb begin
      case (funct3_i)
         F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_LW:   data_o = shifted;
         F3_LBU:  data_o = {24'd0, shifted[7:0]};
         F3_LHU:  data_o = {16'd0, shifted[15:0]};
         default: data_o = 32'd0;
      endcase
   end

endmodule

// File: rtl/unaligned_load_unit.sv
// Load unit that turns byte/half/word loads at any byte address into one or
// two aligned bus reads, then returns the extended result as a single pulse.
module unaligned_load_unit
   import core_mem_pkg::*;
#(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [31:0] ld_addr,
   input  logic [2:0]  ld_funct3,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        rd_err,
   output logic        mem_cyc,
   output logic        mem_stb,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_data_i
);

   ld_state_e   state_q, state_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  f3_q, f3_d;
   logic        split_q, split_d;
   logic [31:0] word1_q, word1_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        stb_q, stb_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        rd_err_q, rd_err_d;

   logic [31:0] ext_w1, ext_w2, ext_data;
   logic        req_split, req_bad;

   assign req_split = ld_split(ld_addr[1:0], ld_funct3);
   assign req_bad   = !ld_legal(ld_funct3) || (req_split && !ALLOW_MISALIGNED);

   // Feed the extractor with the word arriving this cycle so the result can
   // be registered on the final acknowledge (one-cycle response latency).
   always_comb begin
      ext_w1 = (state_q == READ1) ? mem_data_i : word1_q;
      ext_w2 = (state_q == READ2) ? mem_data_i : 32'd0;
   end

   load_extract u_extract (
      .word1_i  (ext_w1),
      .word2_i  (ext_w2),
      .off_i    (off_q),
      .funct3_i (f3_q),
      .data_o   (ext_data)
   );

   // Next-state, bus sequencing and response capture.
   always_comb begin
      state_d    = state_q;
      off_d      = off_q;
      f3_d       = f3_q;
      split_d    = split_q;
      word1_d    = word1_q;
      mem_addr_d = mem_addr_q;
      stb_d      = stb_q;
      rd_data_d  = 32'd0;
      rd_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ld_valid) begin
               off_d   = ld_addr[1:0];
               f3_d    = ld_funct3;
               split_d = req_split;
               word1_d = 32'd0;
               if (req_bad) begin
                  state_d  = RESP;
                  rd_err_d = 1'b1;
               end else begin
                  state_d    = READ1;
                  mem_addr_d = {ld_addr[31:2], 2'b00};
                  stb_d      = 1'b1;
               end
            end
         end
         READ1: begin
            if (mem_ack) begin
               word1_d = mem_data_i;
               stb_d   = 1'b0;
               if (split_q) begin
                  state_d    = READ2;
                  mem_addr_d = mem_addr_q + 32'd4;
               end else begin
                  state_d   = RESP;
                  rd_data_d = ext_data;
               end
            end
         end
         READ2: begin
            // First READ2 cycle is the strobe gap; cycle stays asserted.
            if (!stb_q) begin
               stb_d = 1'b1;
            end else if (mem_ack) begin
               stb_d     = 1'b0;
               state_d   = RESP;
               rd_data_d = ext_data;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and capture registers; reset aborts any bus cycle immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         off_q      <= 2'd0;
         f3_q       <= 3'd0;
         split_q    <= 1'b0;
         word1_q    <= 32'd0;
         mem_addr_q <= 32'd0;
         stb_q      <= 1'b0;
         rd_data_q  <= 32'd0;
         rd_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         off_q      <= off_d;
         f3_q       <= f3_d;
         split_q    <= split_d;
         word1_q    <= word1_d;
         mem_addr_q <= mem_addr_d;
         stb_q      <= stb_d;
         rd_data_q  <= rd_data_d;
         rd_err_q   <= rd_err_d;
      end
   end

   assign ld_ready = (state_q == IDLE);
   assign rd_valid = (state_q == RESP);
   assign rd_data  = rd_data_q;
   assign rd_err   = rd_err_q;
   assign mem_cyc  = (state_q == READ1) || (state_q == READ2);
   assign mem_stb  = stb_q;
   assign mem_addr = mem_addr_q;

endmodule

// File: doc/unaligned_load_unit.md
UNALIGNED_LOAD_UNIT -- requirements
Module: unaligned_load_unit

Interface
REQ-001 SHALL have parameter ALLOW_MISALIGNED, default 1; when 0, loads whose width is not aligned to addr are reported as error instead of split.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ld_valid  input  1  load request present.
REQ-005 SHALL have port ld_ready  output  1  unit idle and accepting a request.
REQ-006 SHALL have port ld_addr  input  32  byte address of load.
REQ-007 SHALL have port ld_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 SHALL have port rd_valid  output  1  one-cycle pulse, result available.
REQ-009 SHALL have port rd_data  output  32  extended load result.
REQ-010 SHALL have port rd_err  output  1  qualifies rd_valid; illegal funct3 or forbidden misalignment.
REQ-011 SHALL have ports mem_cyc, mem_stb  output  1 each  bus cycle/strobe, read-only.
REQ-012 SHALL have port mem_addr  output  32  word address, bits [1:0] always 00.
REQ-013 SHALL have ports mem_ack  input  1, mem_data_i  input  32  read acknowledge and data (little-endian bytes).

Function
REQ-014 SHALL use FSM states IDLE, READ1, READ2, RESP.
REQ-015 SHALL assert ld_ready only in IDLE; request accepted when ld_valid && ld_ready, capturing addr and funct3.
REQ-016 SHALL compute nbytes = 1/2/4 from funct3[1:0]; split = (addr[1:0] + nbytes) > 4.
REQ-017 On accept with legal request: IDLE->READ1, mem_addr = {addr[31:2],2'b00}, mem_cyc=mem_stb=1 from next cycle.
REQ-018 On illegal funct3, or split with ALLOW_MISALIGNED=0: IDLE->RESP without bus activity; rd_err=1, rd_data=0.
REQ-019 In READ1 on mem_ack: capture word1; if split go READ2 with mem_addr = word1 address + 4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000), else go RESP.
REQ-020 In READ2 on mem_ack: capture word2, go RESP; mem_cyc held high continuously across READ1->READ2, mem_stb deasserted one cycle between reads.
REQ-021 mem_cyc/mem_stb SHALL hold steady until mem_ack; unlimited wait states allowed.
REQ-022 Result SHALL be ({word2,word1} >> 8*addr[1:0]) truncated to nbytes, sign-extended for LB/LH, zero-extended for LBU/LHU; word2 treated as 0 when not split.
REQ-023 In RESP: rd_valid=1 for exactly one cycle with registered rd_data/rd_err, then IDLE; latency from final mem_ack to rd_valid = 1 cycle.
REQ-024 rd_data SHALL be 0 whenever rd_valid=0.
REQ-025 mem_ack outside READ1/READ2 SHALL be ignored.

Reset
REQ-026 On rst: state=IDLE, mem_cyc=mem_stb=0, mem_addr=0, rd_valid=0, rd_data=0, rd_err=0, captured words cleared.
REQ-027 rst asserted mid-read SHALL drop mem_cyc/mem_stb immediately and produce no rd_valid for the aborted load.

Structure
REQ-028 funct3 load encodings and state enum SHALL live in shared package core_mem_pkg, reused by the store side.
REQ-029 Byte extraction/extension (REQ-022) SHALL be a combinational sub-module load_extract; FSM, address and capture registers stay in unaligned_load_unit.

Verification
REQ-030 Aligned LW addr 0x100, word 0xDEADBEEF, ack after 2 wait states -> one bus read at 0x100, rd_data 0xDEADBEEF, rd_err 0.
REQ-031 LH addr 0x103, word@0x100=0x80FFFFFF, word@0x104=0xFFFFFF7F -> reads 0x100 then 0x104, rd_data 0x00007F80.
REQ-032 LB addr 0x102 word 0x00800000 -> rd_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 LW addr 0xFFFFFFFE -> second read at 0x00000000, bytes merged correctly.
REQ-034 ALLOW_MISALIGNED=0, LW addr 0x101 -> no mem_stb, rd_valid with rd_err 1; funct3 011 -> same.
REQ-035 rst pulsed while in READ2 awaiting ack -> mem_cyc low asynchronously, no rd_valid, next request serviced normally.
